// File: rtl/palette_lookup_arbiter.sv
// Round-robin arbiter sharing one combinational palette ROM between pixel
// sources; returns the registered RGB lookup tagged with the requester ID.
//
// Ports:
//   Clk, Reset        clock, synchronous active-high reset
//   req, req_index    per-requester request and packed 4-bit colour index
//   grant, pal_index  combinational one-hot grant and ROM index
//   pal_red/green/blue ROM colour for pal_index (combinational input)
//   rsp_valid, rsp_id, rsp_red/green/blue  registered response, 1 cycle later
//   max_wait          sticky worst-case wait, built only when
//                     PAL_ARB_WAIT_MON_EN is defined (else tied to 0)
module palette_lookup_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 4,
  parameter int ID_W    = 2
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*IDX_W-1:0] req_index,
  output logic [NUM_REQ-1:0]       grant,
  output logic [IDX_W-1:0]         pal_index,
  input  logic [3:0]               pal_red,
  input  logic [3:0]               pal_green,
  input  logic [3:0]               pal_blue,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [3:0]               rsp_red,
  output logic [3:0]               rsp_green,
  output logic [3:0]               rsp_blue,
  output logic [7:0]               max_wait
);

  localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] win;
  logic            found;

  // Scan from ptr upward, wrapping; first requester seen wins.
  always_comb begin
    int j;
    found     = 1'b0;
    win       = '0;
    grant     = '0;
    pal_index = '0;
    j         = 0;
    if (!Reset) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        j = int'(ptr) + k;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        if (!found && req[j]) begin
          found = 1'b1;
          win   = j[ID_W-1:0];
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (found && (int'(win) == i)) begin
          grant[i]  = 1'b1;
          pal_index = req_index[i*IDX_W +: IDX_W];
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_red   <= '0;
      rsp_green <= '0;
      rsp_blue  <= '0;
    end else begin
      rsp_valid <= found;
      if (found) begin
        rsp_id    <= win;
        rsp_red   <= pal_red;
        rsp_green <= pal_green;
        rsp_blue  <= pal_blue;
        ptr       <= (win == LAST) ? '0 : win + 1'b1;
      end
    end
  end

`ifdef PAL_ARB_WAIT_MON_EN
  logic [7:0] cnt     [NUM_REQ];
  logic [7:0] cnt_nxt [NUM_REQ];
  logic [7:0] max_nxt;

  // A counter only runs while its owner is requesting and losing;
  // max tracks next values so a wait shows up on the same edge.
  always_comb begin
    max_nxt = max_wait;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_nxt[i] = '0;
      if (req[i] && !grant[i]) begin
        cnt_nxt[i] = (cnt[i] == 8'hFF) ? 8'hFF : cnt[i] + 8'd1;
      end
      if (cnt_nxt[i] > max_nxt) max_nxt = cnt_nxt[i];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      max_wait <= '0;
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else begin
      max_wait <= max_nxt;
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= cnt_nxt[i];
    end
  end
`else
  assign max_wait = 8'd0;
`endif

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Directed, table-driven bench for palette_lookup_arbiter.
// Ports: none (drives clock, reset and a behavioural palette ROM).
module tb_palette_lookup_arbiter;

  logic        Clk;
  logic        Reset;
  logic [2:0]  req;
  logic [11:0] req_index;
  logic [2:0]  grant;
  logic [3:0]  pal_index;
  logic [3:0]  pal_red;
  logic [3:0]  pal_green;
  logic [3:0]  pal_blue;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_red;
  logic [3:0]  rsp_green;
  logic [3:0]  rsp_blue;
  logic [7:0]  max_wait;

  int n_checks;
  int n_fail;

  palette_lookup_arbiter #(
    .NUM_REQ(3),
    .IDX_W(4),
    .ID_W(2)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .req(req),
    .req_index(req_index),
    .grant(grant),
    .pal_index(pal_index),
    .pal_red(pal_red),
    .pal_green(pal_green),
    .pal_blue(pal_blue),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_red(rsp_red),
    .rsp_green(rsp_green),
    .rsp_blue(rsp_blue),
    .max_wait(max_wait)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [11:0] rom(input logic [3:0] idx);
    case (idx)
      4'h4:    rom = 12'hF20;
      4'h8:    rom = 12'hDB0;
      4'h9:    rom = 12'h4CF;
      4'hB:    rom = 12'hD1E;
      default: rom = {idx, ~idx, idx ^ 4'h5};
    endcase
  endfunction

  always_comb {pal_red, pal_green, pal_blue} = rom(pal_index);

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [11:0] idx;
    logic [2:0]  grant;
    logic [3:0]  pal;
    logic        valid;
    logic [1:0]  id;
    logic [11:0] rgb;
    logic [7:0]  mw;
  } vec_t;

  vec_t tbl [16];

  function automatic logic [7:0] mw_exp(input logic [7:0] with_mon);
`ifdef PAL_ARB_WAIT_MON_EN
    mw_exp = with_mon;
`else
    mw_exp = 8'd0 & with_mon;
`endif
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic v,
                           input logic [1:0] id, input logic [11:0] rgb);
    check({tag, ".valid"}, 16'(rsp_valid), 16'(v));
    check({tag, ".id"}, 16'(rsp_id), 16'(id));
    check({tag, ".rgb"}, 16'({rsp_red, rsp_green, rsp_blue}), 16'(rgb));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //         req     idx       grant   pal   v    id     rgb       mw
    tbl[0]  = '{3'b111, 12'hB84, 3'b001, 4'h4, 1'b0, 2'd0, 12'h000, 8'd0};
    tbl[1]  = '{3'b111, 12'hB84, 3'b010, 4'h8, 1'b1, 2'd0, 12'hF20, 8'd1};
    tbl[2]  = '{3'b111, 12'hB84, 3'b100, 4'hB, 1'b1, 2'd1, 12'hDB0, 8'd2};
    tbl[3]  = '{3'b111, 12'hB84, 3'b001, 4'h4, 1'b1, 2'd2, 12'hD1E, 8'd2};
    tbl[4]  = '{3'b111, 12'hB84, 3'b010, 4'h8, 1'b1, 2'd0, 12'hF20, 8'd2};
    tbl[5]  = '{3'b111, 12'hB84, 3'b100, 4'hB, 1'b1, 2'd1, 12'hDB0, 8'd2};
    tbl[6]  = '{3'b000, 12'hB84, 3'b000, 4'h0, 1'b1, 2'd2, 12'hD1E, 8'd2};
    tbl[7]  = '{3'b010, 12'hB94, 3'b010, 4'h9, 1'b0, 2'd2, 12'hD1E, 8'd2};
    tbl[8]  = '{3'b000, 12'hB94, 3'b000, 4'h0, 1'b1, 2'd1, 12'h4CF, 8'd2};
    tbl[9]  = '{3'b000, 12'hB94, 3'b000, 4'h0, 1'b0, 2'd1, 12'h4CF, 8'd2};
    tbl[10] = '{3'b100, 12'hB94, 3'b100, 4'hB, 1'b0, 2'd1, 12'h4CF, 8'd2};
    tbl[11] = '{3'b101, 12'hB94, 3'b001, 4'h4, 1'b1, 2'd2, 12'hD1E, 8'd2};
    tbl[12] = '{3'b101, 12'hB94, 3'b100, 4'hB, 1'b1, 2'd0, 12'hF20, 8'd2};
    tbl[13] = '{3'b001, 12'hB94, 3'b001, 4'h4, 1'b1, 2'd2, 12'hD1E, 8'd2};
    tbl[14] = '{3'b001, 12'hB94, 3'b001, 4'h4, 1'b1, 2'd0, 12'hF20, 8'd2};
    tbl[15] = '{3'b000, 12'hB94, 3'b000, 4'h0, 1'b1, 2'd0, 12'hF20, 8'd2};

    Reset     = 1'b1;
    req       = 3'b111;
    req_index = 12'hB84;

    for (int c = 0; c < 2; c++) begin
      step();
      #3;
      check("rst.grant", 16'(grant), 16'h0);
      check("rst.pal_index", 16'(pal_index), 16'h0);
      check("rst.valid", 16'(rsp_valid), 16'h0);
      check("rst.max_wait", 16'(max_wait), 16'h0);
    end

    step();
    Reset = 1'b0;

    // Inputs applied just after an edge, checked just before the next.
    for (int r = 0; r < 16; r++) begin
      req       = tbl[r].req;
      req_index = tbl[r].idx;
      #3;
      check($sformatf("row%0d.grant", r), 16'(grant), 16'(tbl[r].grant));
      check($sformatf("row%0d.pal", r), 16'(pal_index), 16'(tbl[r].pal));
      check_rsp($sformatf("row%0d", r), tbl[r].valid, tbl[r].id,
                tbl[r].rgb);
      check($sformatf("row%0d.max_wait", r), 16'(max_wait),
            16'(mw_exp(tbl[r].mw)));
      step();
    end

    // Mid-stream reset: ptr is left at 2 before reset hits.
    req       = 3'b111;
    req_index = 12'hB84;
    #3;
    check("mid.a.grant", 16'(grant), 16'b010);
    step();
    Reset = 1'b1;
    #3;
    check("mid.b.grant", 16'(grant), 16'h0);
    check_rsp("mid.b", 1'b1, 2'd1, 12'hDB0);
    step();
    Reset = 1'b0;
    #3;
    check_rsp("mid.c", 1'b0, 2'd0, 12'h000);
    check("mid.c.grant", 16'(grant), 16'b001);
    check("mid.c.max_wait", 16'(max_wait), 16'h0);
    step();
    #3;
    check_rsp("mid.d", 1'b1, 2'd0, 12'hF20);
    check("mid.d.grant", 16'(grant), 16'b010);
    check("mid.d.max_wait", 16'(max_wait), 16'(mw_exp(8'd1)));
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
